ps2_frame_rx: RTL

//  PS/2 device-to-host frame receiver; feeds the keyboard display top (RX_DATA/DATA_VALID -> segment decoders).

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_line_filter.sv | 53 +++++
 rtl/ps2_frame_rx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared constants for the PS/2 device-to-host receiver:
//             frame geometry, default filter/timeout settings and the
//             receiver FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Frame geometry: start + 8 data (LSB first) + odd parity + stop.
    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;

    // Defaults: 8-sample glitch filter, 1 ms inter-edge timeout at 50 MHz.
    localparam int PS2_FILTER_LEN_DEF = 8;
    localparam int PS2_TIMEOUT_DEF    = 50000;

    // Receiver FSM state encoding.
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DATA   = 2'd1;
    localparam logic [1:0] c_ST_PARITY = 2'd2;
    localparam logic [1:0] c_ST_STOP   = 2'd3;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                           input logic                     par);
        return ^{data, par};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_line_filter
//  Purpose  : Brings one raw PS/2 line into the clk domain (2-FF
//             synchroniser) and removes glitches with a saturating run-length
//             filter: the output only changes once FILTER_LEN consecutive
//             synchronised samples disagree with it.
//  Ports    : clk     - system clock
//             rst_n   - synchronous active-low reset (output resets to 1)
//             i_line  - raw asynchronous line
//             o_line  - synchronised, filtered line
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_line
);

    localparam int             c_CW       = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(FILTER_LEN - 1);

    logic [1:0]      r_sync;
    logic            r_filt;
    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
            r_filt <= 1'b1;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            if (r_sync[1] == r_filt) begin
                // Any agreeing sample restarts the run.
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                // This is the FILTER_LEN-th disagreeing sample in a row.
                r_filt <= r_sync[1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_line = r_filt;

endmodule
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_frame_rx
//  Purpose  : PS/2 device-to-host frame receiver. Filters SCL/SDA, detects
//             falling SCL edges, deserialises 11-bit frames and reports each
//             good byte or a parity/framing/timeout error with a one-cycle
//             registered pulse.
//  Ports    : CLOCK      - system clock
//             RESET      - synchronous active-low reset
//             SCL, SDA   - raw PS/2 clock and data lines
//             RX_DATA    - last correctly received byte (held)
//             DATA_VALID - pulse, RX_DATA just updated
//             PARITY_ERR - pulse, frame rejected on parity
//             FRAME_ERR  - pulse, bad stop bit or inter-edge timeout
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = PS2_FILTER_LEN_DEF,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEF
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       SCL,
    input  logic       SDA,
    output logic [7:0] RX_DATA,
    output logic       DATA_VALID,
    output logic       PARITY_ERR,
    output logic       FRAME_ERR
);

    localparam logic [2:0]  c_LAST_BIT = 3'(PS2_DATA_BITS - 1);
    localparam logic [15:0] c_TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    logic                     w_scl_f;
    logic                     w_sda_f;
    logic                     r_scl_d;
    logic                     w_edge;
    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [2:0]               r_bit_cnt;
    logic [PS2_DATA_BITS-1:0] r_shift;
    logic                     r_par_bit;
    logic [15:0]              r_to_cnt;
    logic                     w_timeout;
    logic                     w_frame_done;
    logic                     w_par_ok;
    logic                     w_dv_nxt;
    logic                     w_perr_nxt;
    logic                     w_ferr_nxt;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk    (CLOCK),
        .rst_n  (RESET),
        .i_line (SCL),
        .o_line (w_scl_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk    (CLOCK),
        .rst_n  (RESET),
        .i_line (SDA),
        .o_line (w_sda_f)
    );

    // Falling edge of the filtered clock; SDA is taken from the same cycle.
    assign w_edge = r_scl_d & ~w_scl_f;

    // Timeout only fires in a cycle without an edge, so it never collides
    // with frame evaluation.
    assign w_timeout = (r_state != c_ST_IDLE) && !w_edge && (r_to_cnt == c_TO_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_edge && !w_sda_f) w_state_nxt = c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_timeout)                              w_state_nxt = c_ST_IDLE;
                else if (w_edge && r_bit_cnt == c_LAST_BIT) w_state_nxt = c_ST_PARITY;
            end
            c_ST_PARITY: begin
                if (w_timeout)   w_state_nxt = c_ST_IDLE;
                else if (w_edge) w_state_nxt = c_ST_STOP;
            end
            c_ST_STOP: begin
                if (w_timeout || w_edge) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (registered below) ----------------
    always_comb begin
        w_frame_done = (r_state == c_ST_STOP) && w_edge;
        w_par_ok     = odd_parity_ok(r_shift, r_par_bit);
        w_dv_nxt     = w_frame_done && w_par_ok && w_sda_f;
        // Parity failure takes precedence over a bad stop bit.
        w_perr_nxt   = w_frame_done && !w_par_ok;
        w_ferr_nxt   = (w_frame_done && w_par_ok && !w_sda_f) || w_timeout;
    end

    // ---------------- Datapath: shift register, parity, timeout ----------------
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_scl_d   <= 1'b1;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            r_scl_d <= w_scl_f;

            if (r_state == c_ST_IDLE || w_edge || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end

            if (w_edge) begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                    end
                    c_ST_DATA: begin
                        r_shift[r_bit_cnt] <= w_sda_f;
                        r_bit_cnt          <= r_bit_cnt + 3'd1;
                    end
                    c_ST_PARITY: begin
                        r_par_bit <= w_sda_f;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- Output registers ----------------
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            RX_DATA    <= 8'h00;
            DATA_VALID <= 1'b0;
            PARITY_ERR <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            DATA_VALID <= w_dv_nxt;
            PARITY_ERR <= w_perr_nxt;
            FRAME_ERR  <= w_ferr_nxt;
            if (w_dv_nxt) RX_DATA <= r_shift;
        end
    end

endmodule
`default_nettype wire
